dds_interp_stage: RTL and testbench
===================================

DDS_INTERP_STAGE -- requirements
Module: dds_interp_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the signed sample width on the input and output.
REQ-002 The block SHALL have parameter SEL_MAX, default 4, meaning the maximum interpolation exponent (L_max = 2^SEL_MAX).
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  DATA_W  signed sample from the DDS core.
REQ-006 in_valid  input  1  in_data holds a valid sample.
REQ-007 in_ready  output  1  the block accepts in_data this cycle.
REQ-008 interp_sel  input  3  interpolation exponent; L = 2^min(interp_sel, SEL_MAX).
REQ-009 dac_tick  input  1  single-cycle DAC sample-rate strobe.
REQ-010 dac_data  output  DATA_W  signed interpolated sample, registered.
REQ-011 dac_valid  output  1  one-cycle pulse marking a new dac_data.
REQ-012 underrun  output  1  sticky flag: the sample supply ran dry at a segment boundary.
REQ-013 underrun_clr  input  1  synchronous clear of underrun.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both high at a clock edge.
REQ-015 Sample storage SHALL be x_prev, x_cur and a one-entry hold register with a flag hold_v; in_ready = !hold_v.
REQ-016 States SHALL be IDLE, RUN and STALL; in IDLE an accepted sample s SHALL load x_prev = x_cur = s, set k = 0, latch sel_q and go to RUN; hold_v stays 0.
REQ-017 In RUN or STALL, an accepted sample SHALL write the hold register and set hold_v.
REQ-018 On each dac_tick in RUN, dac_data SHALL be x_prev + ((x_cur - x_prev) * k) >>> sel_q on the next edge, with dac_valid high for that one cycle.
REQ-019 Arithmetic: difference DATA_W+1 bits signed, product DATA_W+1+SEL_MAX bits, arithmetic right shift (floor); the result always lies between x_prev and x_cur, so no saturation SHALL be needed.
REQ-020 k SHALL count 0..L-1 on each tick in RUN; a tick with k = L-1 is a segment boundary.
REQ-021 At a boundary with hold_v = 1, x_prev <= x_cur, x_cur <= hold, hold_v <= 0, k <= 0 and sel_q <= the clamped interp_sel.
REQ-022 At a boundary with hold_v = 0 and a same-cycle transfer, that input SHALL be used directly as in REQ-021 (bypass); no underrun.
REQ-023 At a boundary with no sample available, the block SHALL set underrun, go to STALL, and set x_prev <= x_cur.
REQ-024 In STALL, each dac_tick SHALL output x_cur with a dac_valid pulse; the first accepted sample SHALL load x_prev <= x_cur and x_cur <= sample, set k = 0, latch sel_q and return to RUN; hold_v stays 0.
REQ-025 In IDLE, each dac_tick SHALL output 0 with a dac_valid pulse.
REQ-026 interp_sel changes SHALL take effect only where sel_q is latched; mid-segment changes SHALL be ignored.
REQ-027 With L = 1, every tick SHALL be a boundary and dac_data SHALL equal x_prev (passthrough, one-sample delay).
REQ-028 If underrun_clr and a new underrun occur in the same cycle, set SHALL win.
REQ-029 Latency SHALL be one clk from dac_tick to dac_valid; ticks are at least two clk apart.

Reset
REQ-030 While rst_n is low, the block SHALL hold IDLE with x_prev = x_cur = hold = 0, hold_v = 0, k = 0, sel_q = 0, dac_data = 0, dac_valid = 0 and underrun = 0; in_ready is 1 after reset.
REQ-031 Reset asserted mid-segment SHALL discard all buffered samples; the first post-reset transfer SHALL be treated as a priming sample.

Verification
REQ-032 sel=2, feed 0, 400, 800 with supply always ahead -> dac_data 0,0,0,0, 0,100,200,300, 400,500,600,700.
REQ-033 sel=1, feed -1000, -1000, 1000 -> second segment outputs -1000, 0.
REQ-034 sel=4, x_prev=-32768, x_cur=32767 -> k=15 output 28671; k=0 output -32768.
REQ-035 Stop in_valid after priming sample 500 and next sample 900, sel=1 -> 500,500,500,700, then underrun=1 and 900 repeated until the next sample; feeding 100 then outputs 900, 500.
REQ-036 Change interp_sel 1->3 at k=0 -> current segment finishes with L=2; next segment has 8 ticks.
REQ-037 Assert rst_n low in RUN with hold_v=1 -> all outputs 0 and in_ready=1; the next sample re-primes.

Source files
------------

// File: rtl/dds_interp_stage.sv
// ---------------------------------------------------------------------------
// dds_interp_stage
//
// Purpose:
//   Linear-interpolation upsampler between a DDS core and a DAC. Each input
//   sample marks a segment end point. On every DAC strobe the block outputs a
//   point on the straight line from x_prev to x_cur. A segment is
//   L = 2^min(interp_sel, SEL_MAX) strobes long. A one-entry hold register
//   lets the DDS core run one sample ahead of the DAC.
//
// Ports:
//   clk          : clock, all state changes on its rising edge
//   rst_n        : asynchronous active-low reset
//   in_data      : signed sample from the DDS core
//   in_valid     : in_data holds a valid sample
//   in_ready     : block accepts in_data this cycle (hold register empty)
//   interp_sel   : interpolation exponent, latched only at segment starts
//   dac_tick     : single-cycle DAC sample-rate strobe
//   dac_data     : registered interpolated sample
//   dac_valid    : one-cycle pulse marking a new dac_data
//   underrun     : sticky, set when a segment ended with no sample available
//   underrun_clr : synchronous clear of underrun (a same-cycle set wins)
// ---------------------------------------------------------------------------
module dds_interp_stage #(
   parameter int DATA_W  = 16,
   parameter int SEL_MAX = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               interp_sel,
   input  logic                     dac_tick,
   output logic signed [DATA_W-1:0] dac_data,
   output logic                     dac_valid,
   output logic                     underrun,
   input  logic                     underrun_clr
);

   localparam int PW = DATA_W + 1 + SEL_MAX;

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   state_t                    r_state;
   logic signed [DATA_W-1:0]  r_xPrev;
   logic signed [DATA_W-1:0]  r_xCur;
   logic signed [DATA_W-1:0]  r_hold;
   logic                      r_holdV;
   logic [SEL_MAX-1:0]        r_k;
   logic [2:0]                r_selQ;

   logic                      w_xfer;
   logic                      w_lastTick;
   logic                      w_boundary;
   logic [2:0]                w_selClamp;
   logic [SEL_MAX-1:0]        w_lastK;
   logic signed [DATA_W:0]    w_diff;
   logic signed [PW-1:0]      w_diffExt;
   logic signed [PW-1:0]      w_kExt;
   logic signed [PW-1:0]      w_prod;
   logic signed [PW-1:0]      w_shift;
   logic signed [PW-1:0]      w_sum;
   logic signed [DATA_W-1:0]  w_interp;

   assign in_ready = !r_holdV;
   assign w_xfer   = in_valid && !r_holdV;

   assign w_selClamp = (interp_sel > 3'(SEL_MAX)) ? 3'(SEL_MAX) : interp_sel;
   assign w_lastK    = SEL_MAX'((32'd1 << r_selQ) - 32'd1);
   assign w_lastTick = (r_k == w_lastK);
   assign w_boundary = (r_state == RUN) && dac_tick && w_lastTick;

   // Interpolation datapath. The difference needs one extra bit, the product
   // SEL_MAX more; the arithmetic shift floors, and since k < L the result
   // always lies between x_prev and x_cur, so truncating back to DATA_W is safe.
   assign w_diff    = {r_xCur[DATA_W-1], r_xCur} - {r_xPrev[DATA_W-1], r_xPrev};
   assign w_diffExt = PW'(w_diff);
   assign w_kExt    = PW'({1'b0, r_k});
   assign w_prod    = w_diffExt * w_kExt;
   assign w_shift   = w_prod >>> r_selQ;
   assign w_sum     = PW'(r_xPrev) + w_shift;
   assign w_interp  = w_sum[DATA_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_xPrev   <= '0;
         r_xCur    <= '0;
         r_hold    <= '0;
         r_holdV   <= 1'b0;
         r_k       <= '0;
         r_selQ    <= '0;
         dac_data  <= '0;
         dac_valid <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         dac_valid <= dac_tick;
         // The clear is scheduled first so a set below, later in this block, wins.
         if (underrun_clr) begin
            underrun <= 1'b0;
         end

         case (r_state)
            IDLE: begin
               if (dac_tick) begin
                  dac_data <= '0;
               end
               // First sample primes both end points: a flat first segment.
               if (w_xfer) begin
                  r_xPrev <= in_data;
                  r_xCur  <= in_data;
                  r_k     <= '0;
                  r_selQ  <= w_selClamp;
                  r_state <= RUN;
               end
            end

            RUN: begin
               if (dac_tick) begin
                  dac_data <= w_interp;
                  if (w_lastTick) begin
                     if (r_holdV) begin
                        r_xPrev <= r_xCur;
                        r_xCur  <= r_hold;
                        r_holdV <= 1'b0;
                        r_k     <= '0;
                        r_selQ  <= w_selClamp;
                     end else if (w_xfer) begin
                        // Bypass: a sample arriving exactly at the boundary is used directly.
                        r_xPrev <= r_xCur;
                        r_xCur  <= in_data;
                        r_k     <= '0;
                        r_selQ  <= w_selClamp;
                     end else begin
                        underrun <= 1'b1;
                        r_xPrev  <= r_xCur;
                        r_state  <= STALL;
                     end
                  end else begin
                     r_k <= r_k + SEL_MAX'(1);
                  end
               end
               if (w_xfer && !w_boundary) begin
                  r_hold  <= in_data;
                  r_holdV <= 1'b1;
               end
            end

            STALL: begin
               if (dac_tick) begin
                  dac_data <= r_xCur;
               end
               if (w_xfer) begin
                  r_xPrev <= r_xCur;
                  r_xCur  <= in_data;
                  r_k     <= '0;
                  r_selQ  <= w_selClamp;
                  r_state <= RUN;
               end
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_interp_stage.sv
// ---------------------------------------------------------------------------
// tb_dds_interp_stage
//
// Purpose:
//   Self-checking bench for dds_interp_stage. Each scenario is a list of
//   steps (feed a sample and/or strobe the DAC). Expected dac_data values are
//   pushed to a scoreboard queue when a strobe is driven. A monitor pops and
//   compares them whenever dac_valid is seen. Flag, handshake and reset
//   behaviour is checked by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_dds_interp_stage;

   logic               clk;
   logic               rst_n;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         interp_sel;
   logic               dac_tick;
   logic signed [15:0] dac_data;
   logic               dac_valid;
   logic               underrun;
   logic               underrun_clr;

   typedef struct {
      bit       feed;
      int       data;
      bit       tick;
      int       expData;
      logic [2:0] sel;
      bit       clr;
   } step_t;

   step_t steps[$];
   int    expQ[$];
   int    nChecks = 0;
   int    nFails  = 0;

   dds_interp_stage #(.DATA_W(16), .SEL_MAX(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .interp_sel   (interp_sel),
      .dac_tick     (dac_tick),
      .dac_data     (dac_data),
      .dac_valid    (dac_valid),
      .underrun     (underrun),
      .underrun_clr (underrun_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard consumer: every dac_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n && dac_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("dac_valid_unexpected", 1, 0);
         end else begin
            checkOutput("dac_data", int'(dac_data), expQ.pop_front());
         end
      end
   end

   function automatic void addFeed(input int d, input logic [2:0] s);
      step_t st;
      st.feed = 1'b1; st.data = d; st.tick = 1'b0; st.expData = 0; st.sel = s; st.clr = 1'b0;
      steps.push_back(st);
   endfunction

   function automatic void addTick(input int e, input logic [2:0] s, input bit c = 1'b0);
      step_t st;
      st.feed = 1'b0; st.data = 0; st.tick = 1'b1; st.expData = e; st.sel = s; st.clr = c;
      steps.push_back(st);
   endfunction

   task automatic applyStimulus(input step_t st);
      bit done;
      interp_sel = st.sel;
      if (st.feed) begin
         done = 1'b0;
         @(negedge clk);
         in_data  = 16'(st.data);
         in_valid = 1'b1;
         for (int n = 0; n < 40 && !done; n++) begin
            if (in_ready) begin
               @(posedge clk);
               done = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
         #1;
         in_valid = 1'b0;
         checkOutput("feed_handshake", int'(done), 1);
         @(negedge clk);
      end
      if (st.tick) begin
         @(negedge clk);
         dac_tick     = 1'b1;
         underrun_clr = st.clr;
         expQ.push_back(st.expData);
         @(negedge clk);
         dac_tick     = 1'b0;
         underrun_clr = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic runSteps();
      foreach (steps[i]) applyStimulus(steps[i]);
      steps.delete();
      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drain", expQ.size(), 0);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      dac_tick     = 1'b0;
      underrun_clr = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_dac_data", int'(dac_data), 0);
      checkOutput("reset_dac_valid", int'(dac_valid), 0);
      checkOutput("reset_underrun", int'(underrun), 0);
      checkOutput("reset_in_ready", int'(in_ready), 1);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; interp_sel = 3'd0;
      dac_tick = 1'b0; underrun_clr = 1'b0;

      // L=4 ramp with supply always ahead, plus an IDLE strobe that must read 0.
      $display("[TB] scenario: sel=2 ramp");
      doReset();
      addTick(0, 2);
      addFeed(0, 2); addFeed(400, 2);
      for (int k = 0; k < 4; k++) addTick(0, 2);
      addFeed(800, 2);
      for (int k = 0; k < 4; k++) addTick(k * 100, 2);
      addFeed(1200, 2);
      for (int k = 0; k < 4; k++) addTick(400 + k * 100, 2);
      runSteps();
      checkOutput("ramp_no_underrun", int'(underrun), 0);

      // L=2 with negative values; -1 checks that the shift floors rather than truncates.
      $display("[TB] scenario: sel=1 signed segments");
      doReset();
      addFeed(-1000, 1); addFeed(-1000, 1);
      addTick(-1000, 1); addTick(-1000, 1);
      addFeed(1000, 1);
      addTick(-1000, 1); addTick(-1000, 1);
      addFeed(-1001, 1);
      addTick(-1000, 1); addTick(0, 1);
      addTick(1000, 1); addTick(-1, 1);
      runSteps();

      // Full-scale swing; sel=7 must clamp to SEL_MAX=4 (16 strobes per segment).
      $display("[TB] scenario: full-scale sel clamp");
      doReset();
      addFeed(-32768, 7); addFeed(32767, 7);
      for (int k = 0; k < 16; k++) addTick(-32768, 7);
      addFeed(0, 7);
      for (int k = 0; k < 16; k++) addTick(-32768 + ((65535 * k) >>> 4), 7);
      runSteps();

      // Supply runs dry: underrun, STALL repeats x_cur, then recovery and set-wins-clear.
      $display("[TB] scenario: underrun and stall");
      doReset();
      addFeed(500, 1); addFeed(900, 1);
      addTick(500, 1); addTick(500, 1); addTick(500, 1);
      runSteps();
      checkOutput("underrun_before_dry", int'(underrun), 0);
      addTick(700, 1); addTick(900, 1); addTick(900, 1);
      runSteps();
      checkOutput("underrun_set", int'(underrun), 1);
      checkOutput("stall_in_ready", int'(in_ready), 1);
      @(negedge clk); underrun_clr = 1'b1;
      @(negedge clk); underrun_clr = 1'b0;
      checkOutput("underrun_cleared", int'(underrun), 0);
      addFeed(100, 1);
      addTick(900, 1); addTick(500, 1, 1'b1);
      runSteps();
      checkOutput("underrun_set_wins", int'(underrun), 1);

      // interp_sel change mid-segment only takes effect at the next boundary.
      $display("[TB] scenario: sel change 1->3");
      doReset();
      addFeed(0, 1); addFeed(800, 1);
      addTick(0, 3); addTick(0, 3);
      addFeed(1600, 3);
      for (int k = 0; k < 8; k++) addTick(k * 100, 3);
      addTick(800, 3);
      runSteps();

      // L=1 passthrough: output trails the input stream by one sample.
      $display("[TB] scenario: sel=0 passthrough");
      doReset();
      addFeed(10, 0); addFeed(20, 0);
      addTick(10, 0);
      addFeed(30, 0);
      addTick(10, 0);
      addFeed(40, 0);
      addTick(20, 0);
      runSteps();

      // Reset with the hold register full must discard it; next sample re-primes.
      $display("[TB] scenario: reset mid-run");
      doReset();
      addFeed(100, 1); addFeed(300, 1);
      addTick(100, 1);
      runSteps();
      checkOutput("hold_full_in_ready", int'(in_ready), 0);
      doReset();
      addTick(0, 1);
      addFeed(700, 1);
      for (int k = 0; k < 4; k++) addTick(700, 1);
      runSteps();
      checkOutput("post_reset_underrun", int'(underrun), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
